// File: rtl/parity_frame_accum.sv
// Per-frame XOR/XNOR parity accumulator with beat count and optional parity check; result one cycle after the last beat.
// Input stalls while an unconsumed result is held; input and output may hand off in the same cycle.
module parity_frame_accum #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          INVERT = 1'b1,
  parameter bit          CHECK  = 1'b0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_par,
  input  logic             frm_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             acc;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             fresh;
  logic             beat_par;
  logic             acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             res_par;

  assign accept   = in_valid && in_ready;
  // Anything other than mid-frame starts a new frame, including HOLD during an output handshake.
  assign fresh    = (state != ACCUM);
  assign beat_par = ^in_data;
  assign acc_nxt  = fresh ? beat_par : (acc ^ beat_par);
  assign cnt_nxt  = fresh ? CNT_W'(1)
                  : ((cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1));
  assign res_par  = acc_nxt ^ INVERT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (frm_clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state_nxt = in_last ? HOLD : ACCUM;
        end
        ACCUM: begin
          if (accept && in_last) state_nxt = HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            if (accept) state_nxt = in_last ? HOLD : ACCUM;
            else        state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid = (state == HOLD);
    in_ready  = rst_n && !frm_clr && (!out_valid || out_ready);
  end

  // Result registers change only when a last beat lands, so they stay frozen through HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= 1'b0;
      cnt        <= '0;
      out_parity <= 1'b0;
      out_beats  <= '0;
      out_err    <= 1'b0;
    end else if (frm_clr) begin
      acc <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      if (in_last) begin
        out_parity <= res_par;
        out_beats  <= cnt_nxt;
        out_err    <= CHECK ? (res_par != in_par) : 1'b0;
      end
    end
  end

  a_hold_stable: assert property (@(posedge clk)
    (rst_n && !frm_clr && out_valid && !out_ready)
      |=> (out_valid && $stable(out_parity) && $stable(out_beats) && $stable(out_err)));

  a_no_accept_when_blocked: assert property (@(posedge clk)
    (out_valid && !out_ready) |-> !in_ready);

endmodule
